// File: rtl/imm_gen_pipe.sv
// Registered multi-lane immediate generator (I/S/B/J/U/zimm) with a 2-entry skid buffer.
// Optional one-hot select checker: define IMM_GEN_ONEHOT_CHECK_EN.

module imm_gen_lane #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  logic [5:0]      sel,
  output logic [XLEN-1:0] imm
);
  logic signed [11:0] i_imm;
  logic signed [11:0] s_imm;
  logic signed [12:0] b_imm;
  logic signed [20:0] j_imm;
  logic signed [31:0] u_imm;
  logic               unused;

  assign i_imm  = inst[31:20];
  assign s_imm  = {inst[31:25], inst[11:7]};
  assign b_imm  = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign j_imm  = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign u_imm  = {inst[31:12], 12'b0};
  assign unused = ^inst[6:0];

  // Casting a signed field to XLEN sign-extends; zimm is unsigned so it zero-extends.
  always_comb begin
    imm = '0;
    if (sel[5])      imm = XLEN'(inst[19:15]);
    else if (sel[4]) imm = XLEN'(u_imm);
    else if (sel[3]) imm = XLEN'(j_imm);
    else if (sel[2]) imm = XLEN'(b_imm);
    else if (sel[1]) imm = XLEN'(s_imm);
    else if (sel[0]) imm = XLEN'(i_imm);
  end
endmodule

module imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter int NUM_LANES = 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_flush,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [NUM_LANES*32-1:0]   i_inst,
  input  logic [NUM_LANES*6-1:0]    i_imm_sel,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [NUM_LANES*XLEN-1:0] o_imm,
  output logic [15:0]               o_stall_cnt,
  output logic                      o_sel_err
);
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t state, state_nxt;
  logic [NUM_LANES-1:0][XLEN-1:0] dec_imm, out_q, skid_q;
  logic [NUM_LANES-1:0]           multi;
  logic accept, fire, load_out, load_skid, move_skid;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    imm_gen_lane #(.XLEN(XLEN)) u_lane (
      .inst (i_inst[32*k +: 32]),
      .sel  (i_imm_sel[6*k +: 6]),
      .imm  (dec_imm[k])
    );
    assign multi[k] = |(i_imm_sel[6*k +: 6] & (i_imm_sel[6*k +: 6] - 6'd1));
  end

  // Handshake flags come straight from the state register, so ready has no path from i_ready.
  assign o_valid = (state != EMPTY);
  assign o_ready = (state != FULL);
  assign accept  = i_valid & o_ready;
  assign fire    = o_valid & i_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= EMPTY;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        load_out  = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        if (accept && fire) begin
          load_out = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end else if (fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: if (fire) begin
        move_skid = 1'b1;
        state_nxt = BUSY;
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush drops both entries; a concurrent fire has already been seen downstream.
    if (i_flush) begin
      state_nxt = EMPTY;
      load_out  = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out)       out_q <= dec_imm;
      else if (move_skid) out_q <= skid_q;
      if (load_skid)      skid_q <= dec_imm;
    end
  end

  assign o_imm = out_q;

  always_ff @(posedge i_clk) begin
    if (i_reset)                                    o_stall_cnt <= '0;
    else if (state == FULL && o_stall_cnt != 16'hFFFF) o_stall_cnt <= o_stall_cnt + 16'd1;
  end

`ifdef IMM_GEN_ONEHOT_CHECK_EN
  always_ff @(posedge i_clk) begin
    if (i_reset)                o_sel_err <= 1'b0;
    else if (accept && |multi)  o_sel_err <= 1'b1;
  end
`else
  logic unused;
  assign unused    = ^multi;
  assign o_sel_err = 1'b0;
`endif
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: 32b/1-lane and 64b/2-lane instances sharing clock and reset.
module tb_imm_gen_pipe;
`ifdef IMM_GEN_ONEHOT_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_flush, a_ivalid, a_oready, a_ovalid, a_iready, a_err;
  logic [31:0] a_inst, a_imm;
  logic [5:0]  a_sel;
  logic [15:0] a_cnt;

  logic         b_flush, b_ivalid, b_oready, b_ovalid, b_iready, b_err;
  logic [63:0]  b_inst;
  logic [11:0]  b_sel;
  logic [127:0] b_imm;
  logic [15:0]  b_cnt;

  int n_chk = 0;
  int n_err = 0;

  imm_gen_pipe #(.XLEN(32), .NUM_LANES(1)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_flush(a_flush), .i_valid(a_ivalid), .o_ready(a_oready),
    .i_inst(a_inst), .i_imm_sel(a_sel), .o_valid(a_ovalid), .i_ready(a_iready),
    .o_imm(a_imm), .o_stall_cnt(a_cnt), .o_sel_err(a_err));

  imm_gen_pipe #(.XLEN(64), .NUM_LANES(2)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_flush(b_flush), .i_valid(b_ivalid), .o_ready(b_oready),
    .i_inst(b_inst), .i_imm_sel(b_sel), .o_valid(b_ovalid), .i_ready(b_iready),
    .o_imm(b_imm), .o_stall_cnt(b_cnt), .o_sel_err(b_err));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 0; a_ivalid = 0; a_iready = 1; a_inst = '0; a_sel = '0;
    b_flush = 0; b_ivalid = 0; b_iready = 1; b_inst = '0; b_sel = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", a_ovalid, 0);
    chk("rst_ready", a_oready, 1);
    chk("rst_imm",   a_imm, 0);
    chk("rst_cnt",   a_cnt, 0);
    chk("rst_err",   a_err, 0);
    chk("rst_b_imm", b_imm, 0);

    // single I-type, latency 1, valid for exactly one cycle
    a_ivalid = 1; a_inst = 32'hFFF00093; a_sel = 6'b000001;
    step();
    chk("i_valid", a_ovalid, 1);
    chk("i_imm",   a_imm, 32'hFFFFFFFF);
    a_ivalid = 0;
    step();
    chk("i_one_cycle", a_ovalid, 0);

    // back-to-back S, J, U
    a_ivalid = 1; a_inst = 32'hFE112E23; a_sel = 6'b000010;
    step();
    chk("s_imm", a_imm, 32'hFFFFFFFC);
    a_inst = 32'hFF9FF06F; a_sel = 6'b001000;
    step();
    chk("j_imm", a_imm, 32'hFFFFFFF8);
    a_inst = 32'h123452B7; a_sel = 6'b010000;
    step();
    chk("u_imm",   a_imm, 32'h12345000);
    chk("u_valid", a_ovalid, 1);
    a_ivalid = 0;
    step();
    chk("b2b_drain", a_ovalid, 0);

    // stall with three inputs: 1, 2, 3
    a_iready = 0; a_ivalid = 1; a_sel = 6'b000001; a_inst = 32'h00100093;
    step();
    chk("st_ready1", a_oready, 1);
    a_inst = 32'h00200093;
    step();
    chk("st_ready_drop", a_oready, 0);
    chk("st_hold1", a_imm, 1);
    a_inst = 32'h00300093;
    step();
    chk("st_cnt1", a_cnt, 1);
    chk("st_stable", a_imm, 1);
    step();
    chk("st_cnt2", a_cnt, 2);
    a_iready = 1;
    step();
    chk("st_out2",  a_imm, 2);
    chk("st_rdy2",  a_oready, 1);
    chk("st_cnt3",  a_cnt, 3);
    step();
    chk("st_out3",  a_imm, 3);
    chk("st_val3",  a_ovalid, 1);
    a_ivalid = 0;
    step();
    chk("st_empty", a_ovalid, 0);
    chk("st_cnt_hold", a_cnt, 3);

    // flush while FULL with a new input offered
    a_iready = 0; a_ivalid = 1; a_inst = 32'h00100093;
    step();
    a_inst = 32'h00200093;
    step();
    chk("fl_full", a_oready, 0);
    a_inst = 32'h00700093; a_flush = 1;
    step();
    chk("fl_valid", a_ovalid, 0);
    chk("fl_ready", a_oready, 1);
    chk("fl_cnt",   a_cnt, 4);
    a_flush = 0; a_ivalid = 0; a_iready = 1;
    step();
    chk("fl_gone", a_ovalid, 0);
    a_ivalid = 1; a_inst = 32'h00900093;
    step();
    chk("fl_after", a_imm, 9);
    a_ivalid = 0;
    step();

    // 64-bit, two lanes
    b_ivalid = 1; b_inst = {32'h800002B7, 32'hFFF00093}; b_sel = {6'b010000, 6'b000001};
    step();
    chk("b64_iu", b_imm, {64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFF});
    b_inst = {32'hFE000EE3, 32'h3402D073}; b_sel = {6'b000100, 6'b100000};
    step();
    chk("b64_zb", b_imm, {64'hFFFFFFFFFFFFFFFC, 64'h0000000000000005});
    b_inst = {32'h3402D073, 32'hFFF00093}; b_sel = {6'b100000, 6'b000000};
    step();
    chk("b64_zero_sel", b_imm, {64'h0000000000000005, 64'h0});
    b_ivalid = 0;
    step();
    chk("b64_drain", b_ovalid, 0);

    // multi-bit select: priority decode, sticky error flag
    a_ivalid = 1; a_inst = 32'hFE112E23; a_sel = 6'b000011;
    step();
    chk("mh_imm", a_imm, 32'hFFFFFFFC);
    chk("mh_err", a_err, EXP_ERR);
    a_ivalid = 0; a_flush = 1;
    step();
    a_flush = 0;
    chk("mh_err_flush", a_err, EXP_ERR);
    chk("mh_flush_val", a_ovalid, 0);
    rst = 1;
    step();
    rst = 0;
    chk("mh_err_rst", a_err, 0);
    chk("rst2_cnt",   a_cnt, 0);
    chk("rst2_imm",   a_imm, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, registered immediate generator for the decode stage of the pipelined core. Decodes NUM_LANES instructions per transfer into XLEN-bit immediates.
- Supports I/S/B/J/U types plus the CSR zimm type.
- Sits between the fetch/decode boundary and the ID/EX register.
- Uses a valid/ready handshake with a 2-entry skid buffer, so o_ready is registered and stalls do not create a combinational ready path.

Parameters:
- XLEN, 32, immediate width (32 or 64); all types sign-extend from inst[31] except zimm.
- NUM_LANES, 1, instructions decoded per transfer (1..4).

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_flush  input  1  synchronous pipeline flush (branch mispredict).
- i_valid  input  1  input lanes valid.
- o_ready  output  1  block can accept input this cycle (registered).
- i_inst  input  NUM_LANES*32  instructions; lane k at [32k+31:32k]; bits [6:0] ignored.
- i_imm_sel  input  NUM_LANES*6  per-lane select at [6k+5:6k], as {z, u, j, b, s, i}.
- o_valid  output  1  output immediates valid.
- i_ready  input  1  downstream accepts output.
- o_imm  output  NUM_LANES*XLEN  immediates; lane k at [XLEN*k+XLEN-1:XLEN*k].
- o_stall_cnt  output  16  saturating count of cycles spent in FULL.
- o_sel_err  output  1  sticky illegal-select flag (see Optional Feature).

Behaviour:
- Immediate formats, per lane, with s = inst[31]:
  - I = sext(inst[31:20]).
  - S = sext({inst[31:25], inst[11:7]}).
  - B = sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - J = sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - U = sext({inst[31:12], 12'b0}) to XLEN.
  - Z = zext(inst[19:15]).
- Select priority (highest first): z > u > j > b > s > i. All-zero select gives 0.
- Handshakes: accept = i_valid & o_ready; fire = o_valid & i_ready.
- Storage: output register (OUT) and skid register (SKID). Each holds NUM_LANES immediates.
- States: EMPTY (o_valid=0, o_ready=1), BUSY (o_valid=1, o_ready=1), FULL (o_valid=1, o_ready=0).
- EMPTY:
  - accept: load OUT, go to BUSY.
  - otherwise: stay.
- BUSY:
  - accept & fire: load OUT, stay.
  - accept & !fire: load SKID, go to FULL.
  - !accept & fire: go to EMPTY.
  - neither: hold.
- FULL:
  - fire: OUT <= SKID, go to BUSY.
  - otherwise: hold all contents.
  - i_valid is ignored because o_ready=0.
- Latency: 1 cycle from accept to o_valid when downstream is not stalling. Throughput: 1 transfer per cycle.
- o_imm is stable while o_valid=1 and i_ready=0.
- i_flush has priority over everything:
  - Next state is EMPTY and both entries are invalidated.
  - Data accepted in the flush cycle is discarded.
  - A fire in the same cycle still completes downstream.
  - o_stall_cnt and o_sel_err are unaffected.
- Reset (including mid-transfer):
  - State EMPTY.
  - o_valid=0, o_ready=1, o_imm=0, SKID=0.
  - o_stall_cnt=0, o_sel_err=0.
- o_stall_cnt increments in every cycle the state is FULL and saturates at 16'hFFFF.

Optional Feature:
- Macro: IMM_GEN_ONEHOT_CHECK_EN.
- Defined: on each accept, if any lane's i_imm_sel has more than one bit set, o_sel_err is set on the next edge. It stays set until i_reset. Decoding still follows the priority rule.
- Undefined: the port exists and is tied to 0; no check logic is built.

Test Plan:
- XLEN=32, NUM_LANES=1, i_ready=1; inst 0xFFF00093 with sel 6'b000001 -> o_imm=0xFFFFFFFF with o_valid high exactly 1 cycle after accept.
- Back-to-back single-lane, i_ready=1:
  - 0xFE112E23 with sel S -> 0xFFFFFFFC.
  - 0xFF9FF06F with sel J -> 0xFFFFFFF8.
  - 0x123452B7 with sel U -> 0x12345000.
  - Pass condition: one result per cycle, in order.
- Stall: hold i_ready=0 while streaming 3 inputs.
  - o_ready drops after the 2nd accept; o_stall_cnt counts FULL cycles.
  - Release i_ready: outputs drain in order with no loss or duplication.
- Flush: assert i_flush while FULL and i_valid=1 -> next cycle o_valid=0, o_ready=1; the flush-cycle input never appears.
- XLEN=64, NUM_LANES=2:
  - Lane 0: 0xFFF00093 with sel I -> 0xFFFFFFFFFFFFFFFF.
  - Lane 1: 0x800002B7 with sel U -> 0xFFFFFFFF80000000.
  - Lane 0: csrrwi with rs1 field = 5, sel Z -> 0x0000000000000005.
- Macro defined: sel 6'b000011 with inst 0xFE112E23 -> o_imm is the S result 0xFFFFFFFC and o_sel_err=1. o_sel_err stays 1 through a flush and clears only on i_reset.
